// File: rtl/msk_unmask_reader.sv
// Share-serial unmasking reader: folds one share per cycle into acc.
// Optional build macro: MSK_UNMASK_ZEROIZE_EN (wipe buf/acc on handoff).
`ifndef DEFAULTSHARES
`define DEFAULTSHARES 2
`endif

module msk_unmask_reader #(
  parameter int d     = `DEFAULTSHARES,
  parameter int count = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [count*d-1:0] in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [count-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int KW = $clog2(d);
  localparam logic [KW-1:0] KLAST = KW'(d - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    OUT
  } state_e;

  state_e             state_q;
  logic [count*d-1:0] buf_q;
  logic [count-1:0]   acc_q;
  logic [count-1:0]   acc_d;
  logic [KW-1:0]      k_q;

  // Only share k of each bit is muxed into the XOR this cycle.
  always_comb begin
    acc_d = acc_q;
    for (int i = 0; i < count; i++) begin
      for (int j = 0; j < d; j++) begin
        if (k_q == KW'(j)) begin
          acc_d[i] = acc_q[i] ^ buf_q[i*d+j];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      buf_q   <= '0;
      acc_q   <= '0;
      k_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            buf_q   <= in_data;
            acc_q   <= '0;
            k_q     <= '0;
            state_q <= ACC;
          end
        end
        ACC: begin
          acc_q <= acc_d;
          if (k_q == KLAST) begin
            state_q <= OUT;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            state_q <= IDLE;
`ifdef MSK_UNMASK_ZEROIZE_EN
            buf_q   <= '0;
            acc_q   <= '0;
`endif
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == OUT);

`ifdef MSK_UNMASK_ZEROIZE_EN
  // Partial sums in ACC never reach the port.
  assign out_data = out_valid ? acc_q : '0;
`else
  assign out_data = acc_q;
`endif

endmodule
